// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one iterative integer square-root engine between NREQ requesters.
// Optional watchdog on the engine wait is enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_root,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_err,
    output logic                  eng_stall,
    output logic [WIDTH-1:0]      eng_data,
    input  logic [WIDTH-1:0]      eng_quotient,
    input  logic [WIDTH-1:0]      eng_remainder,
    input  logic                  eng_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] op_reg;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     cand;

    // Round-robin search: first valid requester starting just after the last one served.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end else begin
                cand = cand;
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end else begin
                grant_found = grant_found;
            end
        end
    end

    // Grant is offered only while idle and out of reset.
    always_comb begin
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end else begin
            req_ready = '0;
        end
    end

    // The engine is held in restart during reset and for the single LOAD cycle.
    assign eng_stall = !rst_n || (state == LOAD);
    assign eng_data  = op_reg;
    assign rsp_valid = (state == RESP);

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic          err_reg;
    assign rsp_err = err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    // Controller state machine with registered response fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= IDW'(NREQ - 1);
            id_reg   <= '0;
            op_reg   <= '0;
            rsp_id   <= '0;
            rsp_root <= '0;
            rsp_rem  <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            wd_cnt   <= '0;
            err_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_reg <= req_data[grant_idx*WIDTH +: WIDTH];
                        id_reg <= grant_idx;
                        last   <= grant_idx;
                        state  <= LOAD;
                    end else begin
                        state  <= IDLE;
                    end
                end
                LOAD: begin
`ifdef SQRT_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (eng_ready) begin
                        rsp_root <= eng_quotient;
                        rsp_rem  <= eng_remainder;
                        rsp_id   <= id_reg;
                        state    <= RESP;
`ifdef SQRT_ARB_TIMEOUT_EN
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        // Engine never finished: report an error response instead of hanging.
                        rsp_root <= '0;
                        rsp_rem  <= '0;
                        rsp_id   <= id_reg;
                        err_reg  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wd_cnt   <= wd_cnt + CW'(1);
                        state    <= WAIT;
`else
                    end else begin
                        state    <= WAIT;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
`ifdef SQRT_ARB_TIMEOUT_EN
                        err_reg <= 1'b0;
`endif
                        state   <= IDLE;
                    end else begin
                        state   <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed self-checking bench for sqrt_arbiter with a behavioural iterative sqrt engine.
// Timeout scenario runs only when SQRT_ARB_TIMEOUT_EN is defined.
module tb_sqrt_arbiter;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_root;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  rsp_err;
    logic                  eng_stall;
    logic [WIDTH-1:0]      eng_data;
    logic [WIDTH-1:0]      eng_quotient;
    logic [WIDTH-1:0]      eng_remainder;
    logic                  eng_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt = 0;
    int grant_cnt = 0;
    bit hang = 1'b0;

    sqrt_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
        .eng_stall(eng_stall), .eng_data(eng_data),
        .eng_quotient(eng_quotient), .eng_remainder(eng_remainder),
        .eng_ready(eng_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural engine: restarts on stall, finishes LAT+1 cycles later unless hung.
    logic [WIDTH-1:0] m_op;
    int               m_cnt;
    logic             m_rdy;

    function automatic logic [WIDTH-1:0] isqrt(input logic [WIDTH-1:0] d);
        longint r;
        r = 0;
        while ((r + 1) * (r + 1) <= longint'(d)) r++;
        return WIDTH'(r);
    endfunction

    always @(posedge clk) begin
        if (eng_stall) begin
            m_op  <= eng_data;
            m_cnt <= 0;
            m_rdy <= 1'b0;
        end else if (!m_rdy && !hang) begin
            if (m_cnt == LAT) m_rdy <= 1'b1;
            else              m_cnt <= m_cnt + 1;
        end
    end
    assign eng_quotient  = isqrt(m_op);
    assign eng_remainder = m_op - isqrt(m_op) * isqrt(m_op);
    assign eng_ready     = m_rdy;

    always @(negedge clk) begin
        if (rst_n && eng_stall) stall_cnt++;
        if (req_ready != 4'b0) grant_cnt++;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [WIDTH-1:0] d);
        req_data[id*WIDTH +: WIDTH] = d;
        req_valid[id] = 1'b1;
        #1;
    endtask

    task automatic take_grant(input int exp_g);
        int n;
        n = 0;
        while (req_ready == 4'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("grant", 64'(req_ready), 64'(4'b0001 << exp_g));
        @(negedge clk);
        req_valid[exp_g] = 1'b0;
        check_value("load_stall", 64'(eng_stall), 64'd1);
    endtask

    task automatic await_rsp(input int exp_id, input logic [WIDTH-1:0] root,
                             input logic [WIDTH-1:0] rem, input logic err,
                             input logic [WIDTH-1:0] op);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("rsp_valid", 64'(rsp_valid), 64'd1);
        check_value("rsp_id", 64'(rsp_id), 64'(exp_id));
        check_value("rsp_root", 64'(rsp_root), 64'(root));
        check_value("rsp_rem", 64'(rsp_rem), 64'(rem));
        check_value("rsp_err", 64'(rsp_err), 64'(err));
        check_value("eng_data", 64'(eng_data), 64'(op));
        @(negedge clk);
        check_value("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    int ord_a[4] = '{0, 1, 2, 3};
    int ord_b[4] = '{2, 3, 0, 1};
    int seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_stall", 64'(eng_stall), 64'd1);
        check_value("rst_ready", 64'(req_ready), 64'd0);
        check_value("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_id, rsp_root}, 64'd0);
        check_value("rst_rem_data", {rsp_rem, eng_data}, 64'd0);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests
        set_req(0, 32'd144); take_grant(0); await_rsp(0, 32'd12, 32'd0, 1'b0, 32'd144);
        check_value("one_stall", 64'(stall_cnt), 64'd1);
        check_value("one_grant", 64'(grant_cnt), 64'd1);
        set_req(2, 32'd150); take_grant(2); await_rsp(2, 32'd12, 32'd6, 1'b0, 32'd150);
        set_req(1, 32'd0);   take_grant(1); await_rsp(1, 32'd0,  32'd0, 1'b0, 32'd0);
        set_req(3, 32'd1);   take_grant(3); await_rsp(3, 32'd1,  32'd0, 1'b0, 32'd1);

        // All four valid, last = 3
        for (int i = 0; i < 4; i++) set_req(i, WIDTH'((i + 1) * (i + 1)));
        for (int k = 0; k < 4; k++) begin
            take_grant(ord_a[k]);
            await_rsp(ord_a[k], WIDTH'(ord_a[k] + 1), 32'd0, 1'b0, WIDTH'((ord_a[k] + 1) * (ord_a[k] + 1)));
        end

        // Move last to 1, then all four again
        set_req(1, 32'd25); take_grant(1); await_rsp(1, 32'd5, 32'd0, 1'b0, 32'd25);
        for (int i = 0; i < 4; i++) set_req(i, WIDTH'((i + 1) * (i + 1)));
        for (int k = 0; k < 4; k++) begin
            take_grant(ord_b[k]);
            await_rsp(ord_b[k], WIDTH'(ord_b[k] + 1), 32'd0, 1'b0, WIDTH'((ord_b[k] + 1) * (ord_b[k] + 1)));
        end
        check_value("stall_total", 64'(stall_cnt), 64'd13);

        // Backpressure in RESP with requester 1 waiting
        rsp_ready = 1'b0;
        set_req(0, 32'd64); take_grant(0);
        set_req(1, 32'd36);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            check_value("bp_hold", {25'd0, rsp_valid, req_ready, rsp_id, rsp_root},
                        {25'd0, 1'b1, 4'b0000, 2'd0, 32'd8});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_value("bp_grant_next", 64'(req_ready), 64'd2);
        take_grant(1); await_rsp(1, 32'd6, 32'd0, 1'b0, 32'd36);

        // Reset during WAIT aborts the operation
        set_req(2, 32'd100); take_grant(2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("midrst_stall", 64'(eng_stall), 64'd1);
        @(negedge clk);
        check_value("midrst_rsp", {29'd0, rsp_valid, rsp_err, rsp_id, rsp_root}, 64'd0);
        check_value("midrst_rem_data", {rsp_rem, eng_data}, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_value("midrst_no_rsp", 64'(seen), 64'd0);
        set_req(0, 32'd81); take_grant(0); await_rsp(0, 32'd9, 32'd0, 1'b0, 32'd81);

`ifdef SQRT_ARB_TIMEOUT_EN
        // Hung engine triggers the watchdog
        hang = 1'b1;
        set_req(3, 32'd200); take_grant(3);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < TIMEOUT + 20) begin
                @(negedge clk);
                n++;
            end
            check_value("to_latency", 64'(n), 64'(TIMEOUT + 1));
        end
        await_rsp(3, 32'd0, 32'd0, 1'b1, 32'd200);
        hang = 1'b0;
        set_req(0, 32'd49); take_grant(0); await_rsp(0, 32'd7, 32'd0, 1'b0, 32'd49);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
